// File: rtl/mdu_pkg.sv
// Shared definitions for the signed multiply/divide unit that feeds the CPU's HI/LO registers.
package mdu_pkg;

    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   MDU_WIDTH = 32;
    localparam int   ITER_W    = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on operand magnitudes, one quotient bit per step, signs restored on the outputs.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] remMag, quoMag, dvsMag;
    logic             quoNeg, remNeg;
    logic [WIDTH:0]   partial, diff;
    logic             fits;
    logic [WIDTH-1:0] nextRem, nextQuo;

    // Outputs show the result *after* the current step, so the final step can be
    // captured into hi/lo on the same edge that finishes the division.
    always_comb begin
        partial   = {remMag, quoMag[WIDTH-1]};
        diff      = partial - {1'b0, dvsMag};
        fits      = (partial >= {1'b0, dvsMag});
        nextRem   = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        nextQuo   = {quoMag[WIDTH-2:0], fits};
        quotient  = quoNeg ? -nextQuo : nextQuo;
        remainder = remNeg ? -nextRem : nextRem;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            remMag <= '0;
            quoMag <= '0;
            dvsMag <= '0;
            quoNeg <= 1'b0;
            remNeg <= 1'b0;
        end else if (load) begin
            // The most negative value maps onto its own bit pattern, read as unsigned 2^(W-1).
            remMag <= '0;
            quoMag <= dividend[WIDTH-1] ? -dividend : dividend;
            dvsMag <= divisor[WIDTH-1] ? -divisor : divisor;
            quoNeg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            remNeg <= dividend[WIDTH-1];
        end else if (step) begin
            remMag <= nextRem;
            quoMag <= nextQuo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed MULT/DIV unit: radix-2 Booth multiplier inline, restoring divider as a sub-module.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           fsmState
);

    // Handshake: start is taken only while busy is low (IDLE); the requester then
    // waits for the one-cycle done pulse, at which point hi/lo (or div_zero) are valid.

    localparam int CntW = $clog2(WIDTH);

    state_t           state, nextState;
    logic [CntW-1:0]  cnt;
    logic             lastIter, divLoad, divStep, divByZero;
    logic [WIDTH-1:0] multiplicand, loAcc, nextLoAcc, divQuo, divRem;
    logic [WIDTH:0]   hiAcc, aExt, boothSum, nextHiAcc;
    logic             qm1, nextQm1;

    assign busy     = (state != IDLE);
    assign fsmState = state;
    assign lastIter = (cnt == CntW'(WIDTH - 1));
    assign divStep  = (state == DIV);

    always_comb begin
        nextState = state;
        divLoad   = 1'b0;
        divByZero = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (op == OP_MULT) begin
                    nextState = MULT;
                end else if (b == '0) begin
                    nextState = DONE;
                    divByZero = 1'b1;
                end else begin
                    nextState = DIV;
                    divLoad   = 1'b1;
                end
            end
            MULT, DIV: if (lastIter) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The high accumulator carries one guard bit so subtracting a most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        aExt = {multiplicand[WIDTH-1], multiplicand};
        case ({loAcc[0], qm1})
            2'b01:   boothSum = hiAcc + aExt;
            2'b10:   boothSum = hiAcc - aExt;
            default: boothSum = hiAcc;
        endcase
        {nextHiAcc, nextLoAcc, nextQm1} = {boothSum[WIDTH], boothSum, loAcc};
    end

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .load      (divLoad),
        .step      (divStep),
        .dividend  (a),
        .divisor   (b),
        .quotient  (divQuo),
        .remainder (divRem)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            multiplicand <= '0;
            hiAcc        <= '0;
            loAcc        <= '0;
            qm1          <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            state    <= nextState;
            done     <= (nextState == DONE);
            div_zero <= divByZero;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && op == OP_MULT) begin
                        multiplicand <= a;
                        hiAcc        <= '0;
                        loAcc        <= b;
                        qm1          <= 1'b0;
                    end
                end
                MULT: begin
                    cnt   <= cnt + 1'b1;
                    hiAcc <= nextHiAcc;
                    loAcc <= nextLoAcc;
                    qm1   <= nextQm1;
                    if (lastIter) begin
                        hi <= nextHiAcc[WIDTH-1:0];
                        lo <= nextLoAcc;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (lastIter) begin
                        hi <= divRem;
                        lo <= divQuo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random MULT/DIV against a plain-arithmetic model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    state_t       fsmState;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [W-1:0]   modelHi = '0;
    logic [W-1:0]   modelLo = '0;
    logic [2*W:0]   expQ[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .fsmState (fsmState)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signed arithmetic on 64-bit integers; truncating division keeps the dividend's sign on the remainder.
    function automatic logic [2*W:0] refModel(input logic opIn, input logic [W-1:0] aIn,
                                              input logic [W-1:0] bIn, input logic [W-1:0] prevHi,
                                              input logic [W-1:0] prevLo);
        longint sa, sb, p, q, r;
        logic [63:0] pv, qv, rv;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        if (opIn == OP_MULT) begin
            p  = sa * sb;
            pv = p;
            return {1'b0, pv};
        end
        if (bIn == '0) return {1'b1, prevHi, prevLo};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {1'b0, rv[W-1:0], qv[W-1:0]};
    endfunction

    task automatic runOp(input logic opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                         input bit noise, input bit pokeDone);
        logic [2*W:0] expEntry;
        int  cyc;
        bit  holdOk, busyOk;
        expQ.push_back(refModel(opIn, aIn, bIn, modelHi, modelLo));
        @(negedge clock);
        start = 1'b1; op = opIn; a = aIn; b = bIn;
        @(negedge clock);
        start  = 1'b0;
        cyc    = 1;
        holdOk = 1'b1;
        busyOk = 1'b1;
        checkVal("busyAfterStart", 64'(busy), 64'd1);
        while (!done && cyc < 100) begin
            if (hi !== modelHi || lo !== modelLo) holdOk = 1'b0;
            if (busy !== 1'b1) busyOk = 1'b0;
            if (noise) begin
                a     = $urandom;
                b     = $urandom;
                op    = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 3) == 0);
            end
            @(negedge clock);
            cyc++;
        end
        start    = 1'b0;
        expEntry = expQ.pop_front();
        checkVal("latency", 64'(cyc), expEntry[2*W] ? 64'd1 : 64'd33);
        checkVal("busyAtDone", 64'(busy), 64'd1);
        checkVal("divZero", 64'(div_zero), 64'(expEntry[2*W]));
        checkVal("hi", 64'(hi), 64'(expEntry[2*W-1:W]));
        checkVal("lo", 64'(lo), 64'(expEntry[W-1:0]));
        if (cyc > 1) begin
            checkVal("holdDuringOp", 64'(holdOk), 64'd1);
            checkVal("busyDuringOp", 64'(busyOk), 64'd1);
        end
        modelHi = expEntry[2*W-1:W];
        modelLo = expEntry[W-1:0];
        if (pokeDone) begin
            start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
        end
        @(negedge clock);
        start = 1'b0;
        checkVal("donePulseEnds", 64'(done), 64'd0);
        checkVal("divZeroPulseEnds", 64'(div_zero), 64'd0);
        checkVal("idleAfterDone", 64'(busy), 64'd0);
    endtask

    task automatic resetMidMult();
        int pulses;
        @(negedge clock);
        start = 1'b1; op = OP_MULT; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkVal("resetBusy", 64'(busy), 64'd0);
        checkVal("resetHi", 64'(hi), 64'd0);
        checkVal("resetLo", 64'(lo), 64'd0);
        checkVal("resetDone", 64'(done), 64'd0);
        modelHi = '0;
        modelLo = '0;
        pulses  = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        checkVal("noDoneAfterAbort", 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [W-1:0] corner[6];
        logic [W-1:0] ra, rb;
        logic         rop;
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};

        repeat (3) @(negedge clock);
        checkVal("rstBusy", 64'(busy), 64'd0);
        checkVal("rstDone", 64'(done), 64'd0);
        checkVal("rstDivZero", 64'(div_zero), 64'd0);
        checkVal("rstHiLo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        runOp(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        runOp(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        runOp(OP_DIV, 32'd17, 32'hFFFF_FFFB, 1'b0, 1'b0);
        runOp(OP_DIV, 32'hFFFF_FFEF, 32'd5, 1'b0, 1'b0);
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runOp(OP_MULT, 32'd6, 32'h2AAA_AAAB, 1'b0, 1'b0);
        runOp(OP_DIV, 32'd42, 32'd0, 1'b0, 1'b1);
        resetMidMult();
        runOp(OP_DIV, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0);
        runOp(OP_MULT, 32'hCAFE_F00D, 32'h8765_4321, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = corner[$urandom_range(0, 5)];
                default: rb = W'($urandom);
            endcase
            runOp(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
